// File: rtl/apb_master_bridge.sv
// Bridges an Ibex-style req/gnt/rvalid data port onto an APB3/APB4 master, one transfer at a time.
// An optional ACCESS-phase cycle limit aborts hung slaves with an error response.
module apb_master_bridge #(
  parameter int unsigned APB_ADDR_WIDTH = 9,
  parameter int unsigned APB_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                      HCLK,
  input  logic                      HRESET,
  input  logic                      data_req_i,
  output logic                      data_gnt_o,
  input  logic                      data_we_i,
  input  logic [3:0]                data_be_i,
  input  logic [31:0]               data_addr_i,
  input  logic [APB_DATA_WIDTH-1:0] data_wdata_i,
  output logic                      data_rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] data_rdata_o,
  output logic                      data_err_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [APB_DATA_WIDTH-1:0] PWDATA,
  output logic                      PWRITE,
  output logic [3:0]                PSTRB,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [APB_DATA_WIDTH-1:0] PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  // Abort fires in the ACCESS cycle where the counter already holds LIMIT-1 wait cycles.
  localparam logic [CntW-1:0] CntLimit =
      (TIMEOUT_CYCLES == 0) ? '0 : CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

  state_e                    state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;
  logic [3:0]                pstrb_q, pstrb_d;
  logic [CntW-1:0]           cnt_q, cnt_d;
  logic                      rvalid_q, rvalid_d;
  logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;

  logic unused_addr;
  assign unused_addr = ^data_addr_i[31:APB_ADDR_WIDTH];

  always_comb begin
    state_d    = state_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pwrite_d   = pwrite_q;
    pstrb_d    = pstrb_q;
    cnt_d      = cnt_q;
    rvalid_d   = 1'b0;
    rdata_d    = rdata_q;
    err_d      = err_q;
    data_gnt_o = 1'b0;

    unique case (state_q)
      StIdle: begin
        data_gnt_o = data_req_i;
        if (data_req_i) begin
          paddr_d  = data_addr_i[APB_ADDR_WIDTH-1:0];
          pwdata_d = data_we_i ? data_wdata_i : '0;
          pwrite_d = data_we_i;
          pstrb_d  = data_we_i ? data_be_i : 4'b0000;
          cnt_d    = '0;
          state_d  = StSetup;
        end
      end
      StSetup: begin
        state_d = StAccess;
      end
      StAccess: begin
        if (PREADY) begin
          rvalid_d = 1'b1;
          rdata_d  = pwrite_q ? '0 : PRDATA;
          err_d    = PSLVERR;
          state_d  = StIdle;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CntLimit)) begin
          rvalid_d = 1'b1;
          rdata_d  = '0;
          err_d    = 1'b1;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q  <= StIdle;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      pstrb_q  <= 4'b0000;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
      pwrite_q <= pwrite_d;
      pstrb_q  <= pstrb_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Select/enable decode straight from state so reset drops them asynchronously.
  assign PSEL          = (state_q != StIdle);
  assign PENABLE       = (state_q == StAccess);
  assign PADDR         = paddr_q;
  assign PWDATA        = pwdata_q;
  assign PWRITE        = pwrite_q;
  assign PSTRB         = pstrb_q;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Randomized scoreboard bench for apb_master_bridge: driver, APB slave model and response monitor
// run as independent processes sharing expectation queues.
module tb_apb_master_bridge;

  localparam int unsigned AW = 9;
  localparam int          T  = 4;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        data_req_i = 1'b0;
  logic        data_gnt_o;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_be_i = '0;
  logic [31:0] data_addr_i = '0;
  logic [31:0] data_wdata_i = '0;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        data_err_o;
  logic [AW-1:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE;
  logic [3:0]  PSTRB;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;

  apb_master_bridge #(
    .APB_ADDR_WIDTH(AW),
    .APB_DATA_WIDTH(32),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .data_req_i   (data_req_i),
    .data_gnt_o   (data_gnt_o),
    .data_we_i    (data_we_i),
    .data_be_i    (data_be_i),
    .data_addr_i  (data_addr_i),
    .data_wdata_i (data_wdata_i),
    .data_rvalid_o(data_rvalid_o),
    .data_rdata_o (data_rdata_o),
    .data_err_o   (data_err_o),
    .PADDR        (PADDR),
    .PWDATA       (PWDATA),
    .PWRITE       (PWRITE),
    .PSTRB        (PSTRB),
    .PSEL         (PSEL),
    .PENABLE      (PENABLE),
    .PRDATA       (PRDATA),
    .PREADY       (PREADY),
    .PSLVERR      (PSLVERR)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] prdata;
    logic        slverr;
    int          w;       // PREADY-low cycles the slave inserts
  } txn_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  txn_t slv_q[$];
  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  always @(posedge HCLK) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: a transfer occupies SETUP plus (w+1) ACCESS cycles, capped at T when aborted.
  function automatic exp_t model(input txn_t t, input int gnt_cyc);
    exp_t e;
    int   acc;
    if (t.w >= T) begin
      acc     = T;
      e.rdata = 32'h0;
      e.err   = 1'b1;
    end else begin
      acc     = t.w + 1;
      e.rdata = t.we ? 32'h0 : t.prdata;
      e.err   = t.slverr;
    end
    e.cyc = gnt_cyc + 2 + acc;
    return e;
  endfunction

  // Called at a negedge; returns at the negedge after the grant with req still asserted.
  task automatic issue(input txn_t t, input bit expect_resp);
    int n = 0;
    bit got = 0;
    data_req_i   = 1'b1;
    data_we_i    = t.we;
    data_be_i    = t.be;
    data_addr_i  = t.addr;
    data_wdata_i = t.wdata;
    while (!got && n < 20) begin
      #1;
      if (data_gnt_o === 1'b1) begin
        got = 1;
        slv_q.push_back(t);
        if (expect_resp) sb_q.push_back(model(t, cyc));
      end
      @(negedge HCLK);
      n++;
    end
    if (!got) check("gnt_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    data_req_i = 1'b0;
    repeat (n) @(negedge HCLK);
  endtask

  function automatic txn_t mk(input logic we, input logic [3:0] be, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] prdata,
                              input logic slverr, input int w);
    txn_t t;
    t.we = we; t.be = be; t.addr = addr; t.wdata = wdata;
    t.prdata = prdata; t.slverr = slverr; t.w = w;
    return t;
  endfunction

  // APB slave model: checks the request fields and inserts the requested wait states.
  initial begin : slave
    txn_t cur;
    bit   active = 0;
    int   acc_n = 0;
    bit   rdy;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        active = 0;
        slv_q.delete();
        PREADY = 1'b0;
      end else if (PSEL && !PENABLE) begin
        if (slv_q.size() == 0) begin
          check("setup_unexpected", 32'd1, 32'd0);
        end else begin
          cur    = slv_q.pop_front();
          active = 1;
          acc_n  = 0;
          check("setup_paddr", 32'(PADDR), 32'(cur.addr[AW-1:0]));
          check("setup_pwrite", 32'(PWRITE), 32'(cur.we));
          check("setup_pstrb", 32'(PSTRB), cur.we ? 32'(cur.be) : 32'h0);
          check("setup_pwdata", PWDATA, cur.we ? cur.wdata : 32'h0);
        end
        PREADY  = 1'($urandom_range(0, 1));
        PSLVERR = 1'($urandom_range(0, 1));
        PRDATA  = $urandom;
      end else if (PSEL && PENABLE) begin
        if (!active) begin
          check("access_stray", 32'd1, 32'd0);
          PREADY = 1'b1;
        end else begin
          acc_n++;
          check("access_paddr", 32'(PADDR), 32'(cur.addr[AW-1:0]));
          check("access_pstrb", 32'(PSTRB), cur.we ? 32'(cur.be) : 32'h0);
          check("access_pwdata", PWDATA, cur.we ? cur.wdata : 32'h0);
          rdy     = (acc_n > cur.w);
          PREADY  = rdy;
          PRDATA  = rdy ? cur.prdata : $urandom;
          PSLVERR = rdy ? cur.slverr : 1'($urandom_range(0, 1));
          if (rdy || acc_n >= T) active = 0;
        end
      end else begin
        PREADY  = 1'($urandom_range(0, 1));
        PSLVERR = 1'($urandom_range(0, 1));
        PRDATA  = $urandom;
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge HCLK);
      if (!HRESET && data_rvalid_o === 1'b1) begin
        if (sb_q.size() == 0) begin
          check("rvalid_unexpected", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("resp_rdata", data_rdata_o, e.rdata);
          check("resp_err", 32'(data_err_o), 32'(e.err));
          check("resp_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int   r;
    int   n;
    int   w;
    txn_t t;

    #12;
    check("rst_psel", 32'(PSEL), 32'd0);
    check("rst_penable", 32'(PENABLE), 32'd0);
    check("rst_rvalid", 32'(data_rvalid_o), 32'd0);
    check("rst_gnt", 32'(data_gnt_o), 32'd0);
    check("rst_paddr", 32'(PADDR), 32'd0);
    check("rst_pwdata", PWDATA, 32'd0);
    check("rst_pwrite_pstrb", {27'd0, PWRITE, PSTRB}, 32'd0);
    check("rst_rdata_err", data_rdata_o | 32'(data_err_o), 32'd0);
    @(negedge HCLK);
    HRESET = 1'b0;
    idle(2);

    issue(mk(1'b1, 4'hF, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 1'b0, 0), 1);
    idle(2);
    issue(mk(1'b0, 4'hF, 32'hFFFF_F0A8, 32'h1111_1111, 32'h1234_5678, 1'b0, 3), 1);
    idle(2);
    issue(mk(1'b1, 4'h3, 32'h0000_0010, 32'hCAFE_F00D, 32'h0, 1'b1, 0), 1);
    idle(1);
    issue(mk(1'b0, 4'hF, 32'h0000_0020, 32'h0, 32'h5555_AAAA, 1'b0, 9), 1);
    issue(mk(1'b0, 4'hF, 32'h0000_0024, 32'h0, 32'h0BAD_CAFE, 1'b0, 0), 1);
    idle(1);
    for (int i = 0; i < 3; i++) begin
      issue(mk(1'b1, 4'h1 << i, 32'h200 + 32'(i * 4), 32'hA0 + 32'(i), 32'h0, 1'b0, 0), 1);
    end
    idle(3);

    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(0, 9));
      w = (r < 5) ? 0 : (r < 8) ? int'($urandom_range(1, 3)) : int'($urandom_range(4, 6));
      t = mk(1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom, $urandom,
             ($urandom_range(0, 3) == 0), w);
      issue(t, 1);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(12);

    // Abort an access with reset; no response may follow.
    issue(mk(1'b0, 4'hF, 32'h0000_0044, 32'h0, 32'h7777_7777, 1'b0, 3), 0);
    data_req_i = 1'b0;
    @(negedge HCLK);
    check("pre_rst_penable", 32'(PENABLE), 32'd1);
    #2 HRESET = 1'b1;
    #1;
    check("midrst_psel", 32'(PSEL), 32'd0);
    check("midrst_penable", 32'(PENABLE), 32'd0);
    check("midrst_rvalid", 32'(data_rvalid_o), 32'd0);
    @(negedge HCLK);
    #3 HRESET = 1'b0;
    @(negedge HCLK);
    issue(mk(1'b0, 4'hF, 32'h0000_0048, 32'h0, 32'h8888_0001, 1'b0, 1), 1);
    issue(mk(1'b1, 4'hC, 32'h0000_004C, 32'h9999_0002, 32'h0, 1'b0, 0), 1);
    idle(1);

    n = 0;
    while (sb_q.size() != 0 && n < 50) begin
      @(negedge HCLK);
      n++;
    end
    check("responses_outstanding", 32'(sb_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Converts the core-side data port (req/gnt/rvalid, Ibex-style) into APB3/APB4 master transfers.
- Sits directly upstream of the APB peripherals (apb_timer and siblings), which it drives through their PSEL/PENABLE/PADDR/PWDATA/PWRITE ports.
- Performs one transfer at a time: SETUP phase, then ACCESS phase with PREADY wait states, then a registered response.
- A cycle-count timeout aborts hung accesses with an error response.

Parameters:
- APB_ADDR_WIDTH, 9: width of PADDR. The low APB_ADDR_WIDTH bits of data_addr_i are forwarded.
- APB_DATA_WIDTH, 32: width of PWDATA/PRDATA. Fixed to 32; PSTRB is 4 bits.
- TIMEOUT_CYCLES, 255: maximum ACCESS-phase cycles without PREADY before abort. 0 disables the timeout.

Ports:
- HCLK  in  1  clock
- HRESET  in  1  asynchronous active-high reset
- data_req_i  in  1  core request
- data_gnt_o  out  1  request accepted this cycle
- data_we_i  in  1  1 = write, 0 = read
- data_be_i  in  4  byte enables
- data_addr_i  in  32  byte address
- data_wdata_i  in  32  write data
- data_rvalid_o  out  1  response valid, single-cycle pulse
- data_rdata_o  out  32  read data, valid with rvalid
- data_err_o  out  1  error, valid with rvalid
- PADDR  out  APB_ADDR_WIDTH  APB address
- PWDATA  out  32  APB write data
- PWRITE  out  1  APB direction
- PSTRB  out  4  APB write strobes
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PRDATA  in  32  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB slave error

Behaviour:
- Reset (asynchronous, HRESET=1):
  - State goes to IDLE.
  - All outputs are 0, including the PADDR, PWDATA, PWRITE and PSTRB registers and the timeout counter.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - data_gnt_o = data_req_i, combinational.
  - On data_req_i=1, capture addr[APB_ADDR_WIDTH-1:0], wdata, we, and PSTRB = we ? be : 4'b0000, then go to SETUP.
  - On data_req_i=0, stay in IDLE.
- SETUP (1 cycle): PSEL=1, PENABLE=0, gnt=0. Next state is ACCESS unconditionally.
- ACCESS:
  - Outputs: PSEL=1, PENABLE=1, gnt=0. PADDR, PWDATA, PWRITE and PSTRB stay stable from SETUP through the end of ACCESS.
  - PREADY=1 completes the transfer: register data_rdata_o = PWRITE ? 0 : PRDATA and data_err_o = PSLVERR, pulse data_rvalid_o=1 next cycle, go to IDLE.
  - PREADY=0: increment the timeout counter.
  - Timeout: if TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES with PREADY still 0, abort:
    - drop PSEL/PENABLE next cycle;
    - pulse rvalid with err=1 and rdata=0;
    - go to IDLE.
  - PREADY=1 in the same cycle the counter hits the limit counts as a normal completion; no timeout.
  - The counter clears on entry to SETUP.
- Response timing:
  - data_rvalid_o is high for exactly one cycle: the first IDLE cycle after completion or abort.
  - data_rdata_o/data_err_o hold their values until the next response. They are valid only when qualified by rvalid.
- Back-to-back: a new req may be granted in the same cycle rvalid is high. With zero wait states the minimum cadence is 3 cycles per transfer (gnt, SETUP, ACCESS).
- Latency: gnt at cycle 0, SETUP at 1, ACCESS at 2, rvalid at 3 with zero wait states. Each PREADY-low cycle adds one.
- Reads drive PSTRB=0. PWDATA is driven with the captured wdata on writes and with 0 on reads.
- In IDLE, PSEL=PENABLE=0. PADDR/PWDATA/PWRITE/PSTRB hold their last values (the APB spec permits this).
- A reset asserted mid-transfer aborts immediately: PSEL drops asynchronously and no rvalid is issued.
- PSLVERR is sampled only in the PREADY=1 ACCESS cycle and is ignored otherwise.

Test Plan:
1. Write, zero wait (addr=0x104, wdata=0xDEADBEEF, be=0xF, PREADY tied 1):
   - Expect gnt at cycle 0.
   - Expect PSEL=1/PENABLE=0 at cycle 1 and PENABLE=1 at cycle 2, with PADDR=0x104, PWRITE=1, PSTRB=0xF.
   - Expect rvalid at cycle 3 with err=0 and rdata=0.
2. Read with 3 wait states (PREADY low for 3 ACCESS cycles, PRDATA=0x12345678):
   - Expect ACCESS to last 4 cycles with PADDR stable throughout.
   - Expect rvalid at cycle 6 with rdata=0x12345678 and PSTRB=0.
3. Slave error (write, PSLVERR=1 with PREADY=1) -> rvalid with err=1.
4. Timeout (TIMEOUT_CYCLES=4, PREADY held 0):
   - Expect PSEL to drop after 4 ACCESS cycles.
   - Expect rvalid with err=1 and rdata=0, followed by IDLE.
   - A subsequent read with PREADY=1 completes normally.
5. Back-to-back (req held high for 3 transfers, PREADY=1):
   - Expect gnt on cycles 0, 3 and 6.
   - Expect rvalid on cycles 3, 6 and 9 coinciding with gnt on cycles 3 and 6, with no lost or duplicated responses.
6. Reset mid-ACCESS (HRESET pulsed while PENABLE=1) -> PSEL/PENABLE/rvalid go 0 immediately, no response, and the next request works.
